// File: rtl/tx_serial_reg.sv
// Parallel-to-serial launcher for one output pad: MSB-first, one bit per clk, from a registered flop.
// An optional launch delay sits between word acceptance and the first bit.
module tx_serial_reg #(
    parameter int   WIDTH    = 16,
    parameter int   LEN_W    = 5,
    parameter int   DLY_W    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] len,
    input  logic [DLY_W-1:0] delay,
    input  logic             valid,
    output logic             ready,
    output logic             Q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT} state_t;

    localparam logic [LEN_W-1:0] LP_WIDTH = LEN_W'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_load;
    logic [LEN_W-1:0] r_bcnt;
    logic [LEN_W-1:0] w_len_eff;
    logic [DLY_W-1:0] r_dcnt;
    logic             r_q;
    logic             r_done;
    logic             w_accept;

    // Out-of-range lengths send the full word; the word is left-aligned so the MSB of the
    // selected field always leaves from sr[WIDTH-1].
    always_comb begin
        w_len_eff = len;
        if (len == '0 || len > LP_WIDTH)
            w_len_eff = LP_WIDTH;
        w_sr_load = din << (LP_WIDTH - w_len_eff);
        w_accept  = valid && ready;
    end

    always_ff @(posedge clk) begin
        if (!res_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (delay == '0) ? S_SHIFT : S_DELAY;
            S_DELAY: if (r_dcnt == DLY_W'(1)) w_next = S_SHIFT;
            S_SHIFT: if (r_bcnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == S_IDLE) && res_n;
        busy  = (r_state != S_IDLE);
        Q     = r_q;
        done  = r_done;
    end

    // The first bit is launched on the edge that enters SHIFT, so bcnt holds the bits still
    // pending after it; this gives exactly one idle cycle between back-to-back words.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_sr   <= '0;
            r_bcnt <= '0;
            r_dcnt <= '0;
            r_q    <= IDLE_LVL;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bcnt <= w_len_eff - LEN_W'(1);
                        r_dcnt <= delay;
                        if (delay == '0) begin
                            r_q  <= w_sr_load[WIDTH-1];
                            r_sr <= w_sr_load << 1;
                        end else begin
                            r_sr <= w_sr_load;
                        end
                    end
                end
                S_DELAY: begin
                    r_dcnt <= r_dcnt - DLY_W'(1);
                    if (r_dcnt == DLY_W'(1)) begin
                        r_q  <= r_sr[WIDTH-1];
                        r_sr <= r_sr << 1;
                    end
                end
                S_SHIFT: begin
                    if (r_bcnt != '0) begin
                        r_q    <= r_sr[WIDTH-1];
                        r_sr   <= r_sr << 1;
                        r_bcnt <= r_bcnt - LEN_W'(1);
                    end else begin
                        r_q    <= IDLE_LVL;
                        r_done <= 1'b1;
                    end
                end
                default: r_q <= IDLE_LVL;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_serial_reg.sv
// Directed bench for tx_serial_reg: idle-low instance for most scenarios, idle-high instance
// for the long-delay single-bit case.
module tb_tx_serial_reg;

    logic        clk = 1'b0;
    logic        res_n;
    logic [15:0] din;
    logic [4:0]  len;
    logic [3:0]  delay;
    logic        valid, valid1;
    logic        ready, Q, busy, done;
    logic        ready1, Q1, busy1, done1;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    tx_serial_reg #(.WIDTH(16), .LEN_W(5), .DLY_W(4), .IDLE_LVL(1'b0)) dut0 (
        .clk(clk), .res_n(res_n), .din(din), .len(len), .delay(delay), .valid(valid),
        .ready(ready), .Q(Q), .busy(busy), .done(done));

    tx_serial_reg #(.WIDTH(16), .LEN_W(5), .DLY_W(4), .IDLE_LVL(1'b1)) dut1 (
        .clk(clk), .res_n(res_n), .din(din), .len(len), .delay(delay), .valid(valid1),
        .ready(ready1), .Q(Q1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) n_done = n_done + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_n = 1'b0; valid = 1'b0; valid1 = 1'b0; din = '0; len = '0; delay = '0;
        step(); step();
        n_cmp++;
        if ({Q, busy, ready, done} !== 4'b0000) begin
            n_err++; $display("FAIL reset0 {Q,busy,ready,done}=%b exp=0000", {Q, busy, ready, done});
        end
        n_cmp++;
        if ({Q1, busy1, ready1, done1} !== 4'b1000) begin
            n_err++; $display("FAIL reset1 {Q,busy,ready,done}=%b exp=1000", {Q1, busy1, ready1, done1});
        end
        res_n = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy ready=%b exp=1", ready); end
        step();
    endtask

    task automatic test_full_word();
        logic [15:0] w;
        int d0;
        w = 16'hA5C3; d0 = n_done;
        din = w; len = 5'd16; delay = 4'd0; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({Q, busy, ready, done} !== {w[15-i], 3'b100}) begin
                n_err++; $display("FAIL full_bit%0d {Q,busy,ready,done}=%b exp=%b", i, {Q, busy, ready, done}, {w[15-i], 3'b100});
            end
            step();
        end
        n_cmp++;
        if ({Q, busy, ready, done} !== 4'b0011) begin
            n_err++; $display("FAIL full_end {Q,busy,ready,done}=%b exp=0011", {Q, busy, ready, done});
        end
        step();
        n_cmp++;
        if ({done, n_done - d0} !== {1'b0, 32'd1}) begin
            n_err++; $display("FAIL full_done1 done=%b count=%0d exp 0/1", done, n_done - d0);
        end
    endtask

    task automatic test_delay();
        logic [2:0] w;
        w = 3'b101;
        din = 16'h0005; len = 5'd3; delay = 4'd5; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({Q, busy, ready, done} !== 4'b0100) begin
                n_err++; $display("FAIL dly_wait%0d {Q,busy,ready,done}=%b exp=0100", i, {Q, busy, ready, done});
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({Q, busy} !== {w[2-i], 1'b1}) begin
                n_err++; $display("FAIL dly_bit%0d {Q,busy}=%b exp=%b", i, {Q, busy}, {w[2-i], 1'b1});
            end
            step();
        end
        n_cmp++;
        if ({Q, busy, ready, done} !== 4'b0011) begin
            n_err++; $display("FAIL dly_end {Q,busy,ready,done}=%b exp=0011", {Q, busy, ready, done});
        end
        step();
    endtask

    task automatic test_len_clamp();
        logic [15:0] w;
        w = 16'h8001;
        for (int j = 0; j < 2; j++) begin
            din = w; len = (j == 0) ? 5'd0 : 5'd20; delay = 4'd0; valid = 1'b1;
            step();
            valid = 1'b0;
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if ({Q, busy} !== {w[15-i], 1'b1}) begin
                    n_err++; $display("FAIL clamp%0d_bit%0d {Q,busy}=%b exp=%b", j, i, {Q, busy}, {w[15-i], 1'b1});
                end
                step();
            end
            n_cmp++;
            if ({Q, done} !== 2'b01) begin
                n_err++; $display("FAIL clamp%0d_end {Q,done}=%b exp=01", j, {Q, done});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [3];
        int d0;
        words[0] = 4'hA; words[1] = 4'h3; words[2] = 4'hC; d0 = n_done;
        len = 5'd4; delay = 4'd0; din = {12'h0, words[0]}; valid = 1'b1;
        step();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({Q, busy, ready, done} !== {words[j][3-i], 3'b100}) begin
                    n_err++; $display("FAIL b2b_w%0d_bit%0d {Q,busy,ready,done}=%b exp=%b", j, i, {Q, busy, ready, done}, {words[j][3-i], 3'b100});
                end
                step();
            end
            n_cmp++;
            if ({Q, busy, ready, done} !== 4'b0011) begin
                n_err++; $display("FAIL b2b_gap%0d {Q,busy,ready,done}=%b exp=0011", j, {Q, busy, ready, done});
            end
            if (j < 2) din = {12'h0, words[j+1]};
            else valid = 1'b0;
            step();
        end
        step();
        n_cmp++;
        if ({busy, n_done - d0} !== {1'b0, 32'd3}) begin
            n_err++; $display("FAIL b2b_count busy=%b dones=%0d exp 0/3", busy, n_done - d0);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w;
        int d0;
        din = 16'hA5C3; len = 5'd16; delay = 4'd0; valid = 1'b1;
        step();
        valid = 1'b0;
        step(); step();
        n_cmp++;
        if ({Q, busy} !== 2'b11) begin
            n_err++; $display("FAIL mrst_bit3 {Q,busy}=%b exp=11", {Q, busy});
        end
        d0 = n_done;
        res_n = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL mrst_rdy_low ready=%b exp=0", ready); end
        step();
        res_n = 1'b1;
        #1;
        n_cmp++;
        if ({Q, busy, ready, done} !== 4'b0010) begin
            n_err++; $display("FAIL mrst_after {Q,busy,ready,done}=%b exp=0010", {Q, busy, ready, done});
        end
        step(); step(); step();
        n_cmp++;
        if ({Q, busy, n_done - d0} !== {2'b00, 32'd0}) begin
            n_err++; $display("FAIL mrst_nodone Q=%b busy=%b dones=%0d exp 0/0/0", Q, busy, n_done - d0);
        end
        w = 16'h3C96;
        din = w; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (Q !== w[15-i]) begin
                n_err++; $display("FAIL mrst_next_bit%0d Q=%b exp=%b", i, Q, w[15-i]);
            end
            step();
        end
        n_cmp++;
        if ({Q, done} !== 2'b01) begin
            n_err++; $display("FAIL mrst_next_end {Q,done}=%b exp=01", {Q, done});
        end
        step();
    endtask

    task automatic test_idle_high();
        din = 16'h0000; len = 5'd1; delay = 4'd15; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if ({Q1, busy1} !== 2'b11) begin
                n_err++; $display("FAIL ihi_wait%0d {Q,busy}=%b exp=11", i, {Q1, busy1});
            end
            step();
        end
        n_cmp++;
        if ({Q1, busy1, done1} !== 3'b010) begin
            n_err++; $display("FAIL ihi_bit {Q,busy,done}=%b exp=010", {Q1, busy1, done1});
        end
        step();
        n_cmp++;
        if ({Q1, busy1, ready1, done1} !== 4'b1011) begin
            n_err++; $display("FAIL ihi_end {Q,busy,ready,done}=%b exp=1011", {Q1, busy1, ready1, done1});
        end
        step();
        n_cmp++;
        if ({Q1, done1} !== 2'b10) begin
            n_err++; $display("FAIL ihi_after {Q,done}=%b exp=10", {Q1, done1});
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_delay();
        test_len_clamp();
        test_back_to_back();
        test_mid_reset();
        test_idle_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
